// File: rtl/piso_shift_tx_if.sv
// Handshake and serial-output bundle for piso_shift_tx.
// The master side loads words; the slave side is the transmitter itself.
interface piso_shift_tx_if #(
  parameter int WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] din;
  logic             dir;
  logic             hold;
  logic             sout;
  logic             sout_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output load_valid, din, dir, hold,
    input  load_ready, sout, sout_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  load_valid, din, dir, hold,
    output load_ready, sout, sout_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter, LSB- or MSB-first, with hold and framing strobes.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_shift_tx #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  piso_shift_tx_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] PAR   = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             dir_q;
  logic             sout_q;
  logic             vld_q;
  logic             start_q;
  logic             end_q;
  logic             last_data;
  logic             last_bit;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  function automatic logic pick_bit(input logic [WIDTH-1:0] w, input logic d);
    return d ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] w, input logic d);
    return d ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  // The early-accept window is the final bit of the frame: parity if present, else the last data bit.
  assign last_data = (state == SHIFT) && (cnt == CW'(1));
`ifdef PISO_PARITY_EN
  assign last_bit  = (state == PAR);
`else
  assign last_bit  = last_data;
`endif

  always_comb begin
    bus.load_ready = 1'b0;
    if (!rst)
      bus.load_ready = (state == IDLE) || (last_bit && !bus.hold);
  end

  assign accept = bus.load_valid && bus.load_ready;

  // sreg holds the bits still to be sent; the bit on sout has already been shifted out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      cnt     <= '0;
      dir_q   <= 1'b0;
      sout_q  <= 1'b0;
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      state   <= SHIFT;
      sreg    <= shift_one(bus.din, bus.dir);
      cnt     <= CW'(WIDTH);
      dir_q   <= bus.dir;
      sout_q  <= pick_bit(bus.din, bus.dir);
      vld_q   <= 1'b1;
      start_q <= 1'b1;
      end_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= ^bus.din;
`endif
    end else if (state != IDLE && bus.hold) begin
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      end_q   <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          cnt     <= cnt - CW'(1);
          start_q <= 1'b0;
          if (cnt > CW'(1)) begin
            sout_q <= pick_bit(sreg, dir_q);
            sreg   <= shift_one(sreg, dir_q);
            vld_q  <= 1'b1;
`ifdef PISO_PARITY_EN
            end_q  <= 1'b0;
`else
            end_q  <= (cnt == CW'(2));
`endif
          end else begin
`ifdef PISO_PARITY_EN
            state  <= PAR;
            sout_q <= par_q;
            vld_q  <= 1'b1;
            end_q  <= 1'b1;
`else
            state  <= IDLE;
            vld_q  <= 1'b0;
            end_q  <= 1'b0;
`endif
          end
        end
        PAR: begin
          state   <= IDLE;
          vld_q   <= 1'b0;
          start_q <= 1'b0;
          end_q   <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          vld_q   <= 1'b0;
          start_q <= 1'b0;
          end_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sout        = sout_q;
  assign bus.sout_valid  = vld_q;
  assign bus.frame_start = start_q;
  assign bus.frame_end   = end_q;
  assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_piso_shift_tx.sv
// Directed bench for piso_shift_tx (default build, WIDTH=4).
// Output vector per cycle is {sout_valid, sout, frame_start, frame_end, busy}.
module tb_piso_shift_tx;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  piso_shift_tx_if #(.WIDTH(4)) bus ();

  piso_shift_tx #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [4:0] exp);
    @(negedge clk);
    chk(tag, {3'b000, bus.sout_valid, bus.sout, bus.frame_start, bus.frame_end, bus.busy},
        {3'b000, exp});
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    chk(tag, {4'b0000, bus.sout_valid, bus.frame_start, bus.frame_end, bus.busy}, 8'd0);
  endtask

  task automatic rdy(input string tag, input logic exp);
    #1;
    chk(tag, {7'd0, bus.load_ready}, {7'd0, exp});
  endtask

  initial begin
    rst = 1'b1;
    bus.load_valid = 1'b0;
    bus.din = 4'b0000;
    bus.dir = 1'b0;
    bus.hold = 1'b0;
    repeat (2) @(posedge clk);
    cyc("reset_outputs", 5'b00000);
    rdy("reset_ready_low", 1'b0);
    rst = 1'b0;
    rdy("ready_after_reset", 1'b1);

    // LSB first, 1011 -> 1,1,0,1
    bus.din = 4'b1011; bus.dir = 1'b0; bus.load_valid = 1'b1;
    rdy("lsb_ready", 1'b1);
    cyc("lsb_b0", 5'b11101);
    bus.load_valid = 1'b0; bus.din = 4'b0000;
    cyc("lsb_b1", 5'b11001);
    cyc("lsb_b2", 5'b10001);
    cyc("lsb_b3", 5'b11011);
    rdy("lsb_last_ready", 1'b1);
    idle("lsb_idle");

    // MSB first, 1011 -> 1,0,1,1; hold in IDLE ignored, din/dir changes ignored
    bus.din = 4'b1011; bus.dir = 1'b1; bus.load_valid = 1'b1; bus.hold = 1'b1;
    rdy("idle_hold_ready", 1'b1);
    cyc("msb_b0", 5'b11101);
    bus.load_valid = 1'b0; bus.hold = 1'b0; bus.din = 4'b0100; bus.dir = 1'b0;
    cyc("msb_b1", 5'b10001);
    cyc("msb_b2", 5'b11001);
    cyc("msb_b3", 5'b11011);
    idle("msb_idle");

    // Back-to-back: 1011 then 0110, LSB first
    bus.din = 4'b1011; bus.dir = 1'b0; bus.load_valid = 1'b1;
    cyc("b2b_f1_b0", 5'b11101);
    bus.din = 4'b0110;
    rdy("b2b_busy_not_ready", 1'b0);
    cyc("b2b_f1_b1", 5'b11001);
    cyc("b2b_f1_b2", 5'b10001);
    cyc("b2b_f1_b3", 5'b11011);
    rdy("b2b_early_ready", 1'b1);
    cyc("b2b_f2_b0", 5'b10101);
    bus.load_valid = 1'b0;
    cyc("b2b_f2_b1", 5'b11001);
    cyc("b2b_f2_b2", 5'b11001);
    cyc("b2b_f2_b3", 5'b10011);
    idle("b2b_idle");

    // Hold for 3 cycles after the 2nd bit of 1011
    bus.din = 4'b1011; bus.dir = 1'b0; bus.load_valid = 1'b1;
    cyc("hold_b0", 5'b11101);
    bus.load_valid = 1'b0;
    cyc("hold_b1", 5'b11001);
    bus.hold = 1'b1;
    rdy("hold_ready_low", 1'b0);
    cyc("hold_gap1", 5'b01001);
    cyc("hold_gap2", 5'b01001);
    cyc("hold_gap3", 5'b01001);
    bus.hold = 1'b0;
    cyc("hold_b2", 5'b10001);
    cyc("hold_b3", 5'b11011);
    idle("hold_idle");

    // Hold on the last bit beats a pending handshake
    bus.din = 4'b0110; bus.dir = 1'b1; bus.load_valid = 1'b1;
    cyc("hl_b0", 5'b10101);
    bus.din = 4'b1001; bus.dir = 1'b0;
    cyc("hl_b1", 5'b11001);
    cyc("hl_b2", 5'b11001);
    cyc("hl_b3", 5'b10011);
    rdy("hl_ready_before_hold", 1'b1);
    bus.hold = 1'b1;
    rdy("hl_hold_wins", 1'b0);
    cyc("hl_bubble", 5'b00001);
    bus.hold = 1'b0;
    rdy("hl_ready_after_hold", 1'b1);
    cyc("hl_n_b0", 5'b11101);
    bus.load_valid = 1'b0;
    cyc("hl_n_b1", 5'b10001);
    cyc("hl_n_b2", 5'b10001);
    cyc("hl_n_b3", 5'b11011);
    idle("hl_idle");

    // Reset mid-frame aborts with no resume
    bus.din = 4'b1011; bus.dir = 1'b0; bus.load_valid = 1'b1;
    cyc("mid_b0", 5'b11101);
    bus.load_valid = 1'b0;
    cyc("mid_b1", 5'b11001);
    rst = 1'b1;
    rdy("mid_rst_ready_low", 1'b0);
    @(negedge clk);
    cyc("mid_rst_outputs", 5'b00000);
    rst = 1'b0;
    rdy("mid_ready_after_rst", 1'b1);
    idle("mid_no_resume");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
